pri_encoder_rr: RTL and testbench
=================================

Name: pri_encoder_rr

Overview:
Parametrised N-input request encoder, the registered successor to the combinational 8x3 encoder.
- Captures request pulses into a pending register.
- Selects one pending request per cycle, by fixed priority or round-robin, and presents it as a binary index plus one-hot.
- Output side is a valid/ready handshake, so the consumer can stall it.
- Sits between interrupt/event sources and a single downstream consumer.

Parameters:
N, 8, number of request inputs; legal range 2..64.
W, $clog2(N), index width; derived localparam, not overridable.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req  in  N  request vector; any bit high for one cycle registers a request.
mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin.
out_ready  in  1  consumer accepts the current output.
out_valid  out  1  out_idx/out_onehot hold a granted request.
out_idx  out  W  binary index of the granted request.
out_onehot  out  N  one-hot form of out_idx; all zero when out_valid=0.
pend  out  N  requests captured but not yet issued.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_idx=0, out_onehot=0, pend=0, internal pointer ptr=0. Takes effect immediately without a clock edge. Pending and in-flight requests are discarded.
- Candidates: cand = pend | req (combinational; same-cycle req is eligible).
- Load condition: load = !out_valid || out_ready.
- On a clock edge with load=1:
  - If cand != 0: sel = select(cand, mode, ptr); out_valid<=1; out_idx<=sel; out_onehot<=1<<sel; pend<=cand & ~(1<<sel); ptr<=(sel+1) mod N.
  - If cand == 0: out_valid<=0; out_onehot<=0; out_idx holds its value; pend<=0.
- On a clock edge with load=0 (stall): out_* hold stable; pend<=cand. New requests accumulate during the stall.
- Latency:
  - req asserted in cycle t with a free slot appears on the outputs after edge t (1 cycle).
  - Back-to-back accepts with ready=1 give one grant per cycle, no bubbles.
- Selection:
  - mode=0: lowest set index of cand; ptr is still updated.
  - mode=1: first set bit searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap-around).
  - A mode change applies to the next load.
- Duplicate request:
  - A req bit equal to the index currently held on the output (stalled or being accepted) is a new request and sets pend.
  - A req bit already set in pend is merged (no counting).
- Simultaneous accept and new requests: the accepted grant leaves, and the new selection in the same edge includes same-cycle req.
- out_idx/out_onehot are always mutually consistent when out_valid=1.
- No combinational path from out_ready to any output.

Decomposition:
- Package pri_enc_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1; function onehot(idx, N).
- Sub-module pri_enc_sel (combinational):
  - Inputs: cand[N], ptr[W], mode.
  - Outputs: sel[W], any.
  - Implement as a double-width masked priority search. Instantiated once.
- The top holds pend, ptr and the output registers.

Test Plan:
1. Reset then single request: hold rst_n=0 -> all outputs 0. Release; req=8'h04 for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_idx=2, out_onehot=8'h04; cycle after: out_valid=0, out_onehot=0, pend=0.
2. Fixed-priority ordering: mode=0, req=8'hA0 one cycle, out_ready=1 -> out_idx=5 then 7 on consecutive cycles, then out_valid=0.
3. Stall and accumulate:
   - req=8'h01 pulse, out_ready=0 for 3 cycles -> out_idx=0 held with out_valid=1.
   - req=8'h02 pulse mid-stall -> pend=8'h02.
   - out_ready=1 -> grants 0 then 1, then idle.
4. Round-robin fairness vs fixed priority:
   - req=8'hFF held, out_ready=1, mode=1 -> out_idx 0,1,2,…,7,0.
   - Same stimulus with mode=0 -> out_idx=0 every cycle; pend retains bits 1..7.
5. Wrap-around: mode=1, drive so the last grant is idx 6 (ptr=7), then req=8'h41 pulse -> grant 0 next, then 6.
6. Async reset mid-operation:
   - With out_valid=1 stalled and pend=8'h3C, pulse rst_n low between clock edges -> out_valid, out_onehot, pend go to 0 immediately.
   - After release with no req, out_valid stays 0.

Source files
------------

// File: rtl/pri_enc_pkg.sv
// Shared constants and helpers for the registered round-robin/fixed-priority
// request encoder.
package pri_enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int MAX_N = 64;

    // One-hot of idx within an n-bit vector; out-of-range indices give zero.
    function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
        logic [MAX_N-1:0] v;
        v = '0;
        if (idx >= 0 && idx < n && idx < MAX_N) begin
            v[idx[5:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/pri_enc_sel.sv
// Combinational selector: picks one set bit of cand, either lowest-index-first
// or searching upward from ptr with wrap-around.
module pri_enc_sel
    import pri_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] cand,
    input  logic [W-1:0] ptr,
    input  logic         mode,
    output logic [W-1:0] sel,
    output logic         any
);

    logic [N-1:0]   low_mask;
    logic [2*N-1:0] dbl;
    logic [W:0]     hit;

    // The lower copy holds only bits at or above ptr, the upper copy holds
    // everything, so the lowest set bit of dbl is the first one at or after
    // ptr in circular order. Fixed priority is the ptr == 0 case.
    always_comb begin
        low_mask = (mode == MODE_RR) ? ({N{1'b1}} << ptr) : {N{1'b1}};
        dbl      = {cand, cand & low_mask};
        hit      = '0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (dbl[i]) begin
                hit = (W+1)'(i);
            end
        end
        if (hit >= (W+1)'(N)) begin
            sel = W'(hit - (W+1)'(N));
        end else begin
            sel = W'(hit);
        end
        any = |cand;
    end

endmodule

// File: rtl/pri_encoder_rr.sv
// Registered N-input request encoder: captures request pulses, grants one per
// cycle by fixed priority or round-robin, and presents it on a valid/ready port.
module pri_encoder_rr
    import pri_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic [N-1:0] pend
);

    if (N < 2 || N > MAX_N) begin : g_bad_n
        $error("pri_encoder_rr: N must lie in 2..64");
    end

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic [N-1:0] out_onehot_q, out_onehot_d;
    logic [N-1:0] pend_q, pend_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic [N-1:0] cand;
    logic         load;
    logic [W-1:0] sel;
    logic         any;

    // Handshake: a grant transfers on an edge where out_valid && out_ready.
    // out_valid never drops without a transfer and the payload stays stable
    // while stalled. A new grant loads when the slot is empty or being
    // accepted, so back-to-back grants run at one per cycle.
    assign cand = pend_q | req;
    assign load = !out_valid_q || out_ready;

    pri_enc_sel #(.N(N)) u_sel (
        .cand (cand),
        .ptr  (ptr_q),
        .mode (mode),
        .sel  (sel),
        .any  (any)
    );

    always_comb begin
        out_valid_d  = out_valid_q;
        out_idx_d    = out_idx_q;
        out_onehot_d = out_onehot_q;
        pend_d       = cand;
        ptr_d        = ptr_q;
        if (load) begin
            if (any) begin
                out_valid_d  = 1'b1;
                out_idx_d    = sel;
                out_onehot_d = N'(onehot(int'(sel), N));
                pend_d       = cand & ~N'(onehot(int'(sel), N));
                ptr_d        = (sel == W'(N-1)) ? '0 : W'(sel + 1'b1);
            end else begin
                // Idle: index keeps its last value, one-hot clears.
                out_valid_d  = 1'b0;
                out_onehot_d = '0;
                pend_d       = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            out_onehot_q <= '0;
            pend_q       <= '0;
            ptr_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            out_onehot_q <= out_onehot_d;
            pend_q       <= pend_d;
            ptr_q        <= ptr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign out_onehot = out_onehot_q;
    assign pend       = pend_q;

endmodule

// File: tb/tb_pri_encoder_rr.sv
// Directed bench for pri_encoder_rr with N=8: reset, ordering, stall,
// round-robin vs fixed priority, wrap-around and asynchronous reset.
module tb_pri_encoder_rr;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic         mode;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;
    logic [N-1:0] pend;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pri_encoder_rr #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .mode       (mode),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .pend       (pend)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_idx !== 3'd0) $display("FAIL reset_idx: got %0d expected 0", out_idx);
        else pass_cnt++;
        total_cnt++;
        if (out_onehot !== 8'h00) $display("FAIL reset_onehot: got %h expected 00", out_onehot);
        else pass_cnt++;
        total_cnt++;
        if (pend !== 8'h00) $display("FAIL reset_pend: got %h expected 00", pend);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req = 8'h04;
        tick();
        req = '0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_idx !== 3'd2 || out_onehot !== 8'h04)
            $display("FAIL single_grant: got v=%0b idx=%0d oh=%h expected v=1 idx=2 oh=04",
                     out_valid, out_idx, out_onehot);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0 || out_onehot !== 8'h00 || pend !== 8'h00)
            $display("FAIL single_idle: got v=%0b oh=%h pend=%h expected v=0 oh=00 pend=00",
                     out_valid, out_onehot, pend);
        else pass_cnt++;
        total_cnt++;
        if (out_idx !== 3'd2) $display("FAIL single_idx_hold: got %0d expected 2", out_idx);
        else pass_cnt++;
    endtask

    task automatic test_fixed_order();
        mode      = 1'b0;
        out_ready = 1'b1;
        req       = 8'hA0;
        tick();
        req = '0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_idx !== 3'd5 || out_onehot !== 8'h20 || pend !== 8'h80)
            $display("FAIL fixed_first: got v=%0b idx=%0d oh=%h pend=%h expected v=1 idx=5 oh=20 pend=80",
                     out_valid, out_idx, out_onehot, pend);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_idx !== 3'd7 || out_onehot !== 8'h80 || pend !== 8'h00)
            $display("FAIL fixed_second: got v=%0b idx=%0d oh=%h pend=%h expected v=1 idx=7 oh=80 pend=00",
                     out_valid, out_idx, out_onehot, pend);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL fixed_idle: got %0b expected 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        mode      = 1'b0;
        out_ready = 1'b0;
        req       = 8'h01;
        tick();
        req = '0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_onehot !== 8'h01)
                $display("FAIL stall_hold%0d: got v=%0b idx=%0d oh=%h expected v=1 idx=0 oh=01",
                         i, out_valid, out_idx, out_onehot);
            else pass_cnt++;
            if (i == 1) req = 8'h02;
            tick();
            req = '0;
        end
        total_cnt++;
        if (pend !== 8'h02 || out_idx !== 3'd0 || out_valid !== 1'b1)
            $display("FAIL stall_pend: got pend=%h idx=%0d v=%0b expected pend=02 idx=0 v=1",
                     pend, out_idx, out_valid);
        else pass_cnt++;
        out_ready = 1'b1;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_idx !== 3'd1 || out_onehot !== 8'h02 || pend !== 8'h00)
            $display("FAIL stall_release: got v=%0b idx=%0d oh=%h pend=%h expected v=1 idx=1 oh=02 pend=00",
                     out_valid, out_idx, out_onehot, pend);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL stall_idle: got %0b expected 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_rr_vs_fixed();
        logic [N-1:0] exp_oh;
        int           exp_idx;
        pulse_reset();
        mode      = 1'b1;
        out_ready = 1'b1;
        req       = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_idx = i % N;
            exp_oh  = 8'h01 << exp_idx;
            total_cnt++;
            if (out_valid !== 1'b1 || out_idx !== W'(exp_idx) || out_onehot !== exp_oh)
                $display("FAIL rr_step%0d: got v=%0b idx=%0d oh=%h expected v=1 idx=%0d oh=%h",
                         i, out_valid, out_idx, out_onehot, exp_idx, exp_oh);
            else pass_cnt++;
        end
        req = '0;
        pulse_reset();
        mode = 1'b0;
        req  = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            total_cnt++;
            if (out_valid !== 1'b1 || out_idx !== 3'd0 || pend !== 8'hFE)
                $display("FAIL fixed_starve%0d: got v=%0b idx=%0d pend=%h expected v=1 idx=0 pend=fe",
                         i, out_valid, out_idx, pend);
            else pass_cnt++;
        end
        req = '0;
        pulse_reset();
    endtask

    task automatic test_wrap();
        pulse_reset();
        mode      = 1'b1;
        out_ready = 1'b1;
        req       = 8'h40;
        tick();
        req = 8'h41;
        total_cnt++;
        if (out_valid !== 1'b1 || out_idx !== 3'd6)
            $display("FAIL wrap_setup: got v=%0b idx=%0d expected v=1 idx=6", out_valid, out_idx);
        else pass_cnt++;
        tick();
        req = '0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_onehot !== 8'h01 || pend !== 8'h40)
            $display("FAIL wrap_first: got v=%0b idx=%0d oh=%h pend=%h expected v=1 idx=0 oh=01 pend=40",
                     out_valid, out_idx, out_onehot, pend);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_idx !== 3'd6 || out_onehot !== 8'h40)
            $display("FAIL wrap_second: got v=%0b idx=%0d oh=%h expected v=1 idx=6 oh=40",
                     out_valid, out_idx, out_onehot);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL wrap_idle: got %0b expected 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_duplicate();
        pulse_reset();
        mode      = 1'b0;
        out_ready = 1'b0;
        req       = 8'h08;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_idx !== 3'd3 || pend !== 8'h00)
            $display("FAIL dup_first: got v=%0b idx=%0d pend=%h expected v=1 idx=3 pend=00",
                     out_valid, out_idx, pend);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (pend !== 8'h08) $display("FAIL dup_pend: got %h expected 08", pend);
        else pass_cnt++;
        tick();
        req = '0;
        total_cnt++;
        if (pend !== 8'h08 || out_idx !== 3'd3)
            $display("FAIL dup_merge: got pend=%h idx=%0d expected pend=08 idx=3", pend, out_idx);
        else pass_cnt++;
        out_ready = 1'b1;
        req       = 8'h04;
        tick();
        req = '0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_idx !== 3'd2 || pend !== 8'h08)
            $display("FAIL dup_accept_new: got v=%0b idx=%0d pend=%h expected v=1 idx=2 pend=08",
                     out_valid, out_idx, pend);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_idx !== 3'd3 || out_onehot !== 8'h08 || pend !== 8'h00)
            $display("FAIL dup_regrant: got v=%0b idx=%0d oh=%h pend=%h expected v=1 idx=3 oh=08 pend=00",
                     out_valid, out_idx, out_onehot, pend);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL dup_idle: got %0b expected 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        pulse_reset();
        mode      = 1'b0;
        out_ready = 1'b0;
        req       = 8'h3D;
        tick();
        req = '0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_idx !== 3'd0 || pend !== 8'h3C)
            $display("FAIL arst_setup: got v=%0b idx=%0d pend=%h expected v=1 idx=0 pend=3c",
                     out_valid, out_idx, pend);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_onehot !== 8'h00 || pend !== 8'h00 || out_idx !== 3'd0)
            $display("FAIL arst_immediate: got v=%0b oh=%h pend=%h idx=%0d expected all zero",
                     out_valid, out_onehot, pend, out_idx);
        else pass_cnt++;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (out_valid !== 1'b0 || out_onehot !== 8'h00)
                $display("FAIL arst_after%0d: got v=%0b oh=%h expected v=0 oh=00",
                         i, out_valid, out_onehot);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fixed_order();
        test_stall();
        test_rr_vs_fixed();
        test_wrap();
        test_duplicate();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
